// File: rtl/slc_unit.sv
// Rotate-left unit: combinational barrel result plus a valid-qualified registered copy.
// Build option SLC_PIPE_EN splits the registered barrel with a mid-stage register (latency 2).
module slc_unit #(
    parameter int unsigned N = 32,
    parameter int unsigned K = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [K-1:0] b,
    input  logic         in_valid,
    output logic [N-1:0] r,
    output logic [N-1:0] r_q,
    output logic         out_valid
);

    logic         out_valid_q;
    logic [N-1:0] r_q_d;
    logic         out_valid_d;

    // Full logarithmic barrel for the same-cycle result
    always_comb begin
        r = a;
        for (int i = 0; i < int'(K); i++) begin
            if (b[i]) begin
                r = (r << (1 << i)) | (r >> (N - (1 << i)));
            end
        end
    end

`ifdef SLC_PIPE_EN
    localparam int unsigned H  = (K + 1) / 2;
    localparam int unsigned RB = (K > H) ? (K - H) : 1;

    logic [N-1:0]  p_data_q, p_data_d;
    logic [RB-1:0] p_b_q, p_b_d;
    logic          p_valid_q, p_valid_d;

    // Front half of the barrel plus capture of the still-pending amount bits
    always_comb begin
        p_data_d  = p_data_q;
        p_b_d     = p_b_q;
        p_valid_d = in_valid;
        if (in_valid) begin
            p_data_d = a;
            for (int i = 0; i < int'(H); i++) begin
                if (b[i]) begin
                    p_data_d = (p_data_d << (1 << i)) | (p_data_d >> (N - (1 << i)));
                end
            end
            p_b_d = b[K-1 -: RB];
        end
    end

    // Back half finishes the rotate from the pipeline register
    always_comb begin
        r_q_d       = r_q;
        out_valid_d = p_valid_q;
        if (p_valid_q) begin
            r_q_d = p_data_q;
            for (int j = int'(H); j < int'(K); j++) begin
                if (p_b_q[j-int'(H)]) begin
                    r_q_d = (r_q_d << (1 << j)) | (r_q_d >> (N - (1 << j)));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_q  <= '0;
            p_b_q     <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_data_q  <= p_data_d;
            p_b_q     <= p_b_d;
            p_valid_q <= p_valid_d;
        end
    end
`else
    always_comb begin
        r_q_d       = r_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            r_q_d = r;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_slc_unit.sv
// Self-checking bench for slc_unit: directed vectors, streaming, async reset, random traffic.
module tb_slc_unit;

    localparam int unsigned N = 32;
    localparam int unsigned K = 5;
`ifdef SLC_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a;
    logic [K-1:0] b;
    logic         in_valid;
    logic [N-1:0] r;
    logic [N-1:0] r_q;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference: per-stage valid/result history and the value r_q should hold
    logic         mv [1:LAT];
    logic [N-1:0] md [1:LAT];
    logic [N-1:0] exp_rq;

    slc_unit #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .r        (r),
        .r_q      (r_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
        logic [2*N-1:0] d;
        d = {x, x} << s;
        return d[2*N-1:N];
    endfunction

    task automatic chk(input logic [N-1:0] got, input logic [N-1:0] expv, input string tag);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= int'(LAT); k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        exp_rq = '0;
    endtask

    // Apply one cycle of inputs, check r combinationally, then r_q/out_valid after the edge
    task automatic step(input logic [N-1:0] ta, input logic [K-1:0] tbv, input logic tv,
                        input string tag);
        a = ta; b = tbv; in_valid = tv;
        #1;
        chk(r, rotl(ta, int'(tbv)), {tag, "_r"});
        @(posedge clk);
        for (int k = int'(LAT); k >= 2; k--) begin
            mv[k] = mv[k-1];
            md[k] = md[k-1];
        end
        mv[1] = tv;
        md[1] = rotl(ta, int'(tbv));
        if (mv[LAT]) exp_rq = md[LAT];
        #1;
        chk(N'(out_valid), N'(mv[LAT]), {tag, "_ov"});
        chk(r_q, exp_rq, {tag, "_rq"});
    endtask

    task automatic comb_vec(input logic [N-1:0] ta, input logic [K-1:0] tbv,
                            input logic [N-1:0] rexp, input string tag);
        a = ta; b = tbv; in_valid = 1'b0;
        #1;
        chk(r, rexp, tag);
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0;
        model_reset();
        #12;
        chk(r_q, '0, "reset_rq");
        chk(N'(out_valid), '0, "reset_ov");
        rst_n = 1'b1;

        // Directed combinational vectors
        comb_vec(32'h00000001, 5'd1,  32'h00000002, "walk1");
        comb_vec(32'h00000001, 5'd3,  32'h00000008, "walk3");
        comb_vec(32'h00000001, 5'd7,  32'h00000080, "walk7");
        comb_vec(32'h00000001, 5'd15, 32'h00008000, "walk15");
        comb_vec(32'h00000001, 5'd31, 32'h80000000, "walk31");
        comb_vec(32'h80000001, 5'd1,  32'h00000003, "wrap1");
        comb_vec(32'hF0000000, 5'd4,  32'h0000000F, "wrap4");
        comb_vec(32'hDEADBEEF, 5'd0,  32'hDEADBEEF, "ident");
        comb_vec(32'h12345678, 5'd8,  32'h34567812, "rot8");

        // Single registered op followed by idle cycles
        step(32'h12345678, 5'd8, 1'b1, "single");
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, "single_idle");
        chk(r_q, 32'h34567812, "single_hold");

        // Back-to-back stream
        for (int i = 0; i < 4; i++) step(32'h00000001, K'(i), 1'b1, "stream");
        chk(N'(out_valid), 32'd1, "stream_ov_hi");

        // Asynchronous reset between edges while a result is valid
        rst_n = 1'b0;
        #1;
        chk(r_q, '0, "arst_rq");
        chk(N'(out_valid), '0, "arst_ov");
        model_reset();
        a = 32'hA5A5_0F0F; b = 5'd9; in_valid = 1'b1;
        #1;
        chk(r, rotl(32'hA5A5_0F0F, 9), "arst_r_live");
        @(posedge clk); #1;
        chk(r_q, '0, "arst_hold_rq");
        chk(N'(out_valid), '0, "arst_hold_ov");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step($urandom, K'($urandom), 1'b0, "post_rst");

        // Random traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step($urandom, K'($urandom_range(N-1, 0)), 1'($urandom_range(1, 0)), "rand");
        end
        for (int i = 0; i < int'(LAT) + 1; i++) step('0, '0, 1'b0, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
